// File: rtl/cg_pkg.sv
// Shared types and constants for the clock-gate enable generator.
//   cg_state_e : FSM state encoding (ACTIVE, GATED, WAKE)
//   IDLE_W     : width of the idle down-counter
//   CNT_W_DEF  : default width of the gated-cycle counter
package cg_pkg;
  typedef enum logic [1:0] {ACTIVE, GATED, WAKE} cg_state_e;
  localparam int IDLE_W    = 8;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/cg_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   inc   : count up by one (holds at all-ones)
//   clr   : synchronous clear, wins over inc
//   cnt   : current count
module cg_sat_counter
  import cg_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cg_enable_gen.sv
// Enable generator feeding a clock-gated register. Writes are compared
// against the last loaded value; only real changes produce a one-cycle
// EN_OUT pulse. After IDLE_CYCLES change-free cycles the downstream clock
// is gated off (GATE_N=0); a change or FORCE_ON reopens it through a
// one-cycle WAKE state so the gate is running before the load pulse.
//   CLK, RST_N  : clock, synchronous active-low reset
//   VALID/READY : write handshake, D_IN qualified by VALID
//   FORCE_ON    : keep the downstream clock running
//   CNT_CLR     : clear GATED_CNT
//   D_OUT       : data to the gated register (also the compare shadow)
//   EN_OUT      : load-enable pulse
//   GATE_N      : 1 = downstream clock running
//   GATED_CNT   : saturating count of cycles spent gated
module cg_enable_gen
  import cg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int IDLE_CYCLES = 4,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             VALID,
  input  logic [WIDTH-1:0] D_IN,
  output logic             READY,
  input  logic             FORCE_ON,
  input  logic             CNT_CLR,
  output logic [WIDTH-1:0] D_OUT,
  output logic             EN_OUT,
  output logic             GATE_N,
  output logic [CNT_W-1:0] GATED_CNT
);

  localparam logic [IDLE_W-1:0] IDLE_LD = IDLE_W'(IDLE_CYCLES);

  cg_state_e         state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic [WIDTH-1:0]  d_nxt;
  logic              en_nxt;
  logic              wake_chg, wake_chg_nxt;  // WAKE was entered by a change
  logic              change;

  // D_OUT doubles as the shadow copy for the compare.
  assign change = VALID && READY && (D_IN != D_OUT);

  always_comb begin
    state_nxt    = state;
    idle_nxt     = idle_cnt;
    d_nxt        = D_OUT;
    en_nxt       = 1'b0;
    wake_chg_nxt = wake_chg;
    case (state)
      ACTIVE: begin
        if (change) begin
          d_nxt    = D_IN;
          en_nxt   = 1'b1;
          idle_nxt = IDLE_LD;
        end else if (idle_cnt == '0) begin
          if (!FORCE_ON) state_nxt = GATED;
        end else begin
          idle_nxt = idle_cnt - 1'b1;
        end
      end
      GATED: begin
        // Data loads now so D_OUT is stable through WAKE; the enable
        // pulse is deferred until the gate has reopened.
        if (change) begin
          d_nxt        = D_IN;
          state_nxt    = WAKE;
          wake_chg_nxt = 1'b1;
        end else if (FORCE_ON) begin
          state_nxt    = WAKE;
          wake_chg_nxt = 1'b0;
        end
      end
      WAKE: begin
        state_nxt    = ACTIVE;
        idle_nxt     = IDLE_LD;
        en_nxt       = wake_chg;
        wake_chg_nxt = 1'b0;
      end
      default: state_nxt = ACTIVE;
    endcase
  end

  // READY and GATE_N are registered from the next state so they line up
  // with the state they describe without a combinational decode.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ACTIVE;
      idle_cnt <= IDLE_LD;
      D_OUT    <= '0;
      EN_OUT   <= 1'b0;
      wake_chg <= 1'b0;
      READY    <= 1'b1;
      GATE_N   <= 1'b1;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      D_OUT    <= d_nxt;
      EN_OUT   <= en_nxt;
      wake_chg <= wake_chg_nxt;
      READY    <= (state_nxt != WAKE);
      GATE_N   <= (state_nxt != GATED);
    end
  end

  cg_sat_counter #(.CNT_W(CNT_W)) u_gated_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (state == GATED),
    .clr   (CNT_CLR),
    .cnt   (GATED_CNT)
  );

endmodule

// File: tb/tb_cg_enable_gen.sv
module tb_cg_enable_gen;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0, VALID = 1'b0, FORCE_ON = 1'b0, CNT_CLR = 1'b0;
  logic [7:0] D_IN = '0;
  logic       READY, EN_OUT, GATE_N;
  logic [7:0] D_OUT;
  logic [15:0] GATED_CNT;
  // Narrow-counter instance driven by the same stimulus, for saturation.
  logic       READY4, EN_OUT4, GATE_N4;
  logic [7:0] D_OUT4;
  logic [3:0] GATED_CNT4;
  int total = 0, bad = 0;

  always #5 CLK = ~CLK;

  cg_enable_gen #(.WIDTH(8), .IDLE_CYCLES(4), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .VALID(VALID), .D_IN(D_IN), .READY(READY),
    .FORCE_ON(FORCE_ON), .CNT_CLR(CNT_CLR), .D_OUT(D_OUT), .EN_OUT(EN_OUT),
    .GATE_N(GATE_N), .GATED_CNT(GATED_CNT));

  cg_enable_gen #(.WIDTH(8), .IDLE_CYCLES(4), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .VALID(VALID), .D_IN(D_IN), .READY(READY4),
    .FORCE_ON(FORCE_ON), .CNT_CLR(CNT_CLR), .D_OUT(D_OUT4), .EN_OUT(EN_OUT4),
    .GATE_N(GATE_N4), .GATED_CNT(GATED_CNT4));

  // Advance one cycle; outputs are sampled 1ns after the edge.
  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 0; VALID = 1; D_IN = 8'hFF;
    step(3);
    total++; if (D_OUT !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h exp=00", D_OUT); end
    total++; if (EN_OUT !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", EN_OUT); end
    total++; if (GATE_N !== 1'b1) begin bad++; $display("FAIL rst_gate got=%b exp=1", GATE_N); end
    total++; if (READY !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", READY); end
    total++; if (GATED_CNT !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", GATED_CNT); end
    RST_N = 1; VALID = 0;
  endtask

  // Change in ACTIVE, then a same-value write, then idle until gated.
  task automatic test_change_and_gate;
    VALID = 1; D_IN = 8'hA5;
    step();  // cycle e
    total++; if (D_OUT !== 8'hA5) begin bad++; $display("FAIL chg_dout got=%h exp=a5", D_OUT); end
    total++; if (EN_OUT !== 1'b1) begin bad++; $display("FAIL chg_en got=%b exp=1", EN_OUT); end
    VALID = 0;
    step();  // e+1
    total++; if (EN_OUT !== 1'b0) begin bad++; $display("FAIL chg_en_pulse got=%b exp=0", EN_OUT); end
    VALID = 1; D_IN = 8'hA5;
    step();  // e+2
    total++; if (EN_OUT !== 1'b0) begin bad++; $display("FAIL same_en got=%b exp=0", EN_OUT); end
    total++; if (D_OUT !== 8'hA5) begin bad++; $display("FAIL same_dout got=%h exp=a5", D_OUT); end
    VALID = 0;
    for (int i = 3; i <= 4; i++) begin
      step();
      total++; if (GATE_N !== 1'b1) begin bad++; $display("FAIL gate_early c=e+%0d got=%b exp=1", i, GATE_N); end
    end
    step();  // e+5
    total++; if (GATE_N !== 1'b0) begin bad++; $display("FAIL gate_e5 got=%b exp=0", GATE_N); end
    total++; if (GATED_CNT !== 16'd0) begin bad++; $display("FAIL gate_cnt0 got=%0d exp=0", GATED_CNT); end
    step(10);
    total++; if (GATED_CNT !== 16'd10) begin bad++; $display("FAIL gate_cnt10 got=%0d exp=10", GATED_CNT); end
    total++; if (GATED_CNT4 !== 4'd10) begin bad++; $display("FAIL gate_cnt10_w4 got=%0d exp=10", GATED_CNT4); end
    total++; if (EN_OUT !== 1'b0) begin bad++; $display("FAIL gated_en got=%b exp=0", EN_OUT); end
  endtask

  task automatic test_wake;
    VALID = 1; D_IN = 8'hA5;
    step();
    total++; if (GATE_N !== 1'b0) begin bad++; $display("FAIL gsame_gate got=%b exp=0", GATE_N); end
    total++; if (EN_OUT !== 1'b0) begin bad++; $display("FAIL gsame_en got=%b exp=0", EN_OUT); end
    D_IN = 8'h3C;
    step();  // WAKE
    VALID = 0;
    total++; if (READY !== 1'b0) begin bad++; $display("FAIL wake_ready got=%b exp=0", READY); end
    total++; if (GATE_N !== 1'b1) begin bad++; $display("FAIL wake_gate got=%b exp=1", GATE_N); end
    total++; if (EN_OUT !== 1'b0) begin bad++; $display("FAIL wake_en got=%b exp=0", EN_OUT); end
    total++; if (D_OUT !== 8'h3C) begin bad++; $display("FAIL wake_dout got=%h exp=3c", D_OUT); end
    total++; if (GATED_CNT !== 16'd12) begin bad++; $display("FAIL wake_cnt got=%0d exp=12", GATED_CNT); end
    step();  // ACTIVE
    total++; if (EN_OUT !== 1'b1) begin bad++; $display("FAIL wake_act_en got=%b exp=1", EN_OUT); end
    total++; if (READY !== 1'b1) begin bad++; $display("FAIL wake_act_ready got=%b exp=1", READY); end
    total++; if (D_OUT !== 8'h3C) begin bad++; $display("FAIL wake_act_dout got=%h exp=3c", D_OUT); end
  endtask

  task automatic test_force_collision;
    step(4);
    total++; if (GATE_N !== 1'b1) begin bad++; $display("FAIL f_pre_gate got=%b exp=1", GATE_N); end
    step();
    total++; if (GATE_N !== 1'b0) begin bad++; $display("FAIL f_gated got=%b exp=0", GATE_N); end
    FORCE_ON = 1;
    step();  // WAKE
    total++; if (READY !== 1'b0) begin bad++; $display("FAIL f_wake_ready got=%b exp=0", READY); end
    total++; if (GATE_N !== 1'b1) begin bad++; $display("FAIL f_wake_gate got=%b exp=1", GATE_N); end
    step();  // ACTIVE, no pulse
    total++; if (EN_OUT !== 1'b0) begin bad++; $display("FAIL f_act_en got=%b exp=0", EN_OUT); end
    for (int i = 0; i < 20; i++) begin
      step();
      total++; if (GATE_N !== 1'b1 || EN_OUT !== 1'b0) begin bad++; $display("FAIL f_hold i=%0d gate=%b en=%b exp gate=1 en=0", i, GATE_N, EN_OUT); end
    end
    // Counter is 0 here; a change in the same cycle keeps ACTIVE.
    FORCE_ON = 0; VALID = 1; D_IN = 8'h5A;
    step();
    VALID = 0;
    total++; if (GATE_N !== 1'b1) begin bad++; $display("FAIL col_gate got=%b exp=1", GATE_N); end
    total++; if (EN_OUT !== 1'b1) begin bad++; $display("FAIL col_en got=%b exp=1", EN_OUT); end
    total++; if (D_OUT !== 8'h5A) begin bad++; $display("FAIL col_dout got=%h exp=5a", D_OUT); end
  endtask

  task automatic test_clr_and_sat;
    step(5);
    total++; if (GATE_N !== 1'b0) begin bad++; $display("FAIL s_gated got=%b exp=0", GATE_N); end
    CNT_CLR = 1;
    step();
    CNT_CLR = 0;
    total++; if (GATED_CNT !== 16'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", GATED_CNT); end
    step();
    total++; if (GATED_CNT !== 16'd1) begin bad++; $display("FAIL clr_cnt1 got=%0d exp=1", GATED_CNT); end
    step(19);
    total++; if (GATED_CNT !== 16'd20) begin bad++; $display("FAIL sat_cnt16 got=%0d exp=20", GATED_CNT); end
    total++; if (GATED_CNT4 !== 4'hF) begin bad++; $display("FAIL sat_cnt4 got=%h exp=f", GATED_CNT4); end
  endtask

  task automatic test_reset_mid_wake;
    VALID = 1; D_IN = 8'h77;
    step();  // WAKE
    VALID = 0;
    total++; if (READY !== 1'b0) begin bad++; $display("FAIL rw_wake got=%b exp=0", READY); end
    RST_N = 0;
    step();
    RST_N = 1;
    total++; if (D_OUT !== 8'h00) begin bad++; $display("FAIL rw_dout got=%h exp=00", D_OUT); end
    total++; if (EN_OUT !== 1'b0) begin bad++; $display("FAIL rw_en got=%b exp=0", EN_OUT); end
    total++; if (READY !== 1'b1 || GATE_N !== 1'b1) begin bad++; $display("FAIL rw_rdy_gate got=%b%b exp=11", READY, GATE_N); end
    total++; if (GATED_CNT !== 16'd0) begin bad++; $display("FAIL rw_cnt got=%0d exp=0", GATED_CNT); end
    step();
    total++; if (EN_OUT !== 1'b0) begin bad++; $display("FAIL rw_post_en got=%b exp=0", EN_OUT); end
  endtask

  initial begin
    test_reset;
    test_change_and_gate;
    test_wake;
    test_force_collision;
    test_clr_and_sat;
    test_reset_mid_wake;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
